// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter
//   Shares the system bus between the CPU, which owns it by default, and
//   NUM_REQ secondary masters. It uses the 8088 HOLD/HLDA handshake:
//   HOLD is raised, the arbiter waits for HLDA, grants one requester
//   round-robin, then hands the bus back. After every grant the CPU keeps
//   the bus for MIN_CPU_CYCLES CPU clocks before the next HOLD.
// Ports:
//   clock             system clock
//   reset             synchronous, active-high reset
//   cpu_clock_posedge one-clock strobe at each CPU clock rising edge
//   req               level request per master; held while using the bus
//   HLDA              CPU hold acknowledge, already synchronized to clock
//   HOLD              registered hold request to the CPU
//   grant             registered one-hot bus grant
//   bus_owned         high while any grant bit is set
//   grant_overrun     one-clock pulse when a grant reaches MAX_GRANT_CYCLES
module bus_hold_arbiter #(
  parameter int unsigned NUM_REQ          = 2,
  parameter int unsigned MIN_CPU_CYCLES   = 4,
  parameter int unsigned MAX_GRANT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_clock_posedge,
  input  logic [NUM_REQ-1:0] req,
  input  logic               HLDA,
  output logic               HOLD,
  output logic [NUM_REQ-1:0] grant,
  output logic               bus_owned,
  output logic               grant_overrun
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GW = (MAX_GRANT_CYCLES > 0) ? $clog2(MAX_GRANT_CYCLES + 1) : 1;
  localparam int unsigned CW = (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;

  localparam logic [GW-1:0] GRANT_MAX  = GW'(MAX_GRANT_CYCLES);
  localparam logic [GW-1:0] GRANT_LAST = GW'(MAX_GRANT_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(MIN_CPU_CYCLES - 1);
  localparam logic [IW-1:0] LAST_INIT  = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD_WAIT,
    S_GRANTED,
    S_RELEASE,
    S_COOLDOWN
  } state_t;

  state_t               state, state_n;
  logic                 hold_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic                 overrun_n;
  logic [IW-1:0]        last_grant, last_grant_n;
  logic [GW-1:0]        grant_cnt, grant_cnt_n;
  logic [CW-1:0]        cool_cnt, cool_cnt_n;
  logic [IW-1:0]        winner;
  logic [IW-1:0]        cand;
  logic                 found;

  assign bus_owned = |grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      HOLD          <= 1'b0;
      grant         <= '0;
      grant_overrun <= 1'b0;
      last_grant    <= LAST_INIT;
      grant_cnt     <= '0;
      cool_cnt      <= '0;
    end else begin
      state         <= state_n;
      HOLD          <= hold_n;
      grant         <= grant_n;
      grant_overrun <= overrun_n;
      last_grant    <= last_grant_n;
      grant_cnt     <= grant_cnt_n;
      cool_cnt      <= cool_cnt_n;
    end
  end

  // Round-robin search starting just above the previous winner, wrapping.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_n      = state;
    hold_n       = HOLD;
    grant_n      = grant;
    overrun_n    = 1'b0;
    last_grant_n = last_grant;
    grant_cnt_n  = grant_cnt;
    cool_cnt_n   = cool_cnt;

    case (state)
      S_IDLE: begin
        // HLDA is deliberately ignored here: HOLD must always go out first.
        if (|req) begin
          state_n = S_HOLD_WAIT;
          hold_n  = 1'b1;
        end
      end

      S_HOLD_WAIT: begin
        hold_n = 1'b1;
        if (HLDA) begin
          if (|req) begin
            state_n          = S_GRANTED;
            grant_n          = '0;
            grant_n[winner]  = 1'b1;
            last_grant_n     = winner;
            grant_cnt_n      = '0;
          end else begin
            state_n = S_RELEASE;
            hold_n  = 1'b0;
          end
        end
      end

      S_GRANTED: begin
        if (cpu_clock_posedge && (grant_cnt != GRANT_MAX))
          grant_cnt_n = grant_cnt + 1'b1;
        if (!HLDA) begin
          // CPU took the bus back: abort wins over any overrun report.
          state_n = S_RELEASE;
          hold_n  = 1'b0;
          grant_n = '0;
        end else begin
          // Overrun fires only on the strobe that reaches the limit, so the
          // saturated counter cannot retrigger it.
          overrun_n = cpu_clock_posedge && (grant_cnt == GRANT_LAST);
          if (!req[last_grant]) begin
            state_n = S_RELEASE;
            hold_n  = 1'b0;
            grant_n = '0;
          end
        end
      end

      S_RELEASE: begin
        hold_n = 1'b0;
        if (!HLDA) begin
          if (MIN_CPU_CYCLES == 0) begin
            state_n = S_IDLE;
          end else begin
            state_n    = S_COOLDOWN;
            cool_cnt_n = '0;
          end
        end
      end

      S_COOLDOWN: begin
        hold_n = 1'b0;
        if (cpu_clock_posedge) begin
          if (cool_cnt == COOL_LAST)
            state_n = S_IDLE;
          else
            cool_cnt_n = cool_cnt + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        hold_n  = 1'b0;
        grant_n = '0;
      end
    endcase
  end

endmodule

// File: doc/bus_hold_arbiter.md
Name: bus_hold_arbiter

Overview:
- Shares the PCjr system bus between the CPU (default owner) and NUM_REQ secondary masters, such as the video fetch engine and the refresh sequencer.
- Uses the 8088 HOLD/HLDA handshake: raises HOLD, waits for HLDA, grants one requester round-robin, then returns the bus to the CPU.
- After every grant, guarantees the CPU a minimum number of bus clocks before the next HOLD.
- Sits beside the bus-cycle decoder, which already gates the command strobes with HLDA.

Parameters:
- NUM_REQ, 2, number of secondary bus requesters (1..8).
- MIN_CPU_CYCLES, 4, cpu_clock_posedge pulses the CPU keeps the bus after HLDA drops (0 = none).
- MAX_GRANT_CYCLES, 64, cpu_clock_posedge pulses in GRANTED before grant_overrun fires.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_clock_posedge  input  1  one-clock strobe at each CPU clock rising edge
- req  input  NUM_REQ  level request per master; held until finished with the bus
- HLDA  input  1  CPU hold acknowledge, already synchronized to clock
- HOLD  output  1  hold request to the CPU, registered
- grant  output  NUM_REQ  one-hot bus grant, registered
- bus_owned  output  1  high while any grant bit is set
- grant_overrun  output  1  one-clock pulse when a grant reaches MAX_GRANT_CYCLES

Behaviour:
- Reset values: HOLD=0, grant=0, bus_owned=0, grant_overrun=0, state=IDLE, last_grant=NUM_REQ-1 (so req[0] wins first), both counters=0.
- Reset mid-operation drops HOLD and grant on the next clock, regardless of HLDA.
- IDLE: if |req=1, go to HOLD_WAIT; HOLD=1 on the next clock (1-clock latency).
- HOLD_WAIT: HOLD=1.
  - HLDA=1 and |req=1: select a winner and go to GRANTED; grant[winner]=1 on the next clock.
  - HLDA=1 and req=0 (request withdrawn): go to RELEASE.
  - Waits indefinitely for HLDA; there is no timeout.
- Winner selection: round-robin, searching from index last_grant+1 upward with wrap-around. last_grant is updated to the winner.
  - Selection is evaluated on the clock HLDA is seen, not when HOLD was raised.
- GRANTED: HOLD=1, grant one-hot, bus_owned=1.
  - The grant counter increments on each cpu_clock_posedge and saturates at MAX_GRANT_CYCLES.
  - On the clock the counter reaches MAX_GRANT_CYCLES, grant_overrun pulses once. The grant is not revoked.
  - req[winner]=0: grant=0 and HOLD=0 on the next clock; go to RELEASE.
  - HLDA falls unexpectedly: grant=0 and HOLD=0 on the next clock; go to RELEASE. The abort takes priority over overrun.
  - Requests from other masters are ignored until the next arbitration round.
- RELEASE: HOLD=0, wait for HLDA=0.
  - Then go to COOLDOWN with the cooldown counter cleared, or straight to IDLE if MIN_CPU_CYCLES=0.
- COOLDOWN: HOLD=0.
  - Count cpu_clock_posedge pulses; at MIN_CPU_CYCLES go to IDLE.
  - Pending requests wait. There are never back-to-back grants without a CPU window.
- Simultaneous events:
  - req and HLDA rising on the same clock in IDLE: HLDA is ignored; HOLD is still raised first.
  - Winner deasserts req on the same clock as the overrun: grant drops and the overrun pulse is still emitted.
- Invariants:
  - grant is nonzero only while HOLD=1 and HLDA=1 (checked one clock after the HLDA sample).
  - $onehot0(grant) always holds.
- Counter widths: $clog2(MAX_GRANT_CYCLES+1) and $clog2(MIN_CPU_CYCLES+1); both are saturating.

Test Plan:
- Single request: req=01 at t; HLDA=1 at t+3 → HOLD=1 from t+1, grant=01 at t+4, bus_owned=1; req=00 at t+10 → grant=00 and HOLD=0 at t+11; HLDA=0 → after 4 cpu_clock_posedge, IDLE.
- Round-robin: req=11 held, HLDA tracks HOLD after 2 clocks → grants alternate 01, 10, 01; each separated by ≥4 cpu_clock_posedge with HOLD=0.
- Withdrawal: req=10 raised then dropped before HLDA; HLDA=1 → grant stays 00, HOLD=0 next clock, RELEASE entered.
- Overrun: MAX_GRANT_CYCLES=8, winner holds req for 12 cpu_clock_posedge → grant_overrun single pulse on the 8th, grant remains until req drops.
- HLDA abort and reset: HLDA forced 0 during GRANTED → grant=00 and HOLD=0 next clock. Separately, reset asserted in GRANTED → all outputs 0 next clock; with req=11 afterwards, first grant=01.
